// File: rtl/uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// STATUS bit positions and the receive FSM state encoding.
package uart_rx_pkg;

    localparam logic [3:0] ADDR_RX_DATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS  = 4'h4;
    localparam logic [3:0] ADDR_CTRL    = 4'h8;

    localparam int STATUS_NONEMPTY  = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVR       = 2;
    localparam int STATUS_FERR      = 3;
    localparam int STATUS_PERR      = 4;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO for the UART receiver. A push while full is ignored
// unless a pop in the same cycle frees the slot.
module rx_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [Width-1:0]         i_wdata,
    output logic [Width-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(Depth):0]   o_count
);

    localparam int Aw = $clog2(Depth);
    localparam logic [Aw-1:0] PtrOne   = Aw'(1);
    localparam logic [Aw:0]   CountOne = (Aw + 1)'(1);
    localparam logic [Aw:0]   CountMax = (Aw + 1)'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [Aw-1:0]    r_wptr;
    logic [Aw-1:0]    r_rptr;
    logic [Aw:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CountMax);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PtrOne;
            if (w_do_pop)  r_rptr <= r_rptr + PtrOne;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CountOne;
                2'b01:   r_count <= r_count - CountOne;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only visible once written, so a reset tree would be wasted.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx_dev.sv
// Bus-attached UART receiver: 8N1 deserialiser feeding a byte FIFO with
// data/status/control registers. Define UART_RX_PARITY_EN for 8E1 frames.
module uart_rx_dev
    import uart_rx_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        rx_irq_o
);

    localparam int ClksPerBit = ClockFrequency / BaudRate;
    localparam int CntW       = $clog2(ClksPerBit);
    localparam int FifoAw     = $clog2(FifoDepth);
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    rx_state_e       r_state;
    rx_state_e       w_state_next;
    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    logic [1:0]      r_sync_primed;
    logic [CntW-1:0] r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_ie;
    logic            r_ovr;
    logic            r_ferr;
    logic            r_rvalid;
    logic [31:0]     r_rdata;

    logic            w_fall;
    logic            w_bit_tick;
    logic            w_shift_en;
    logic            w_push;
    logic            w_ferr_set;
    logic            w_pop;
    logic            w_ovr_set;
    logic            w_ovr_clr;
    logic            w_ferr_clr;
    logic            w_rd;
    logic            w_wr;
    logic [3:0]      w_req_off;
    logic [31:0]     w_status;
    logic [31:0]     w_rdata_next;
    logic [7:0]      w_fifo_rdata;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [FifoAw:0] w_fifo_count;
    logic            w_unused_bus;

`ifdef UART_RX_PARITY_EN
    logic            r_par_err;
    logic            r_perr;
    logic            w_perr_set;
    logic            w_perr_clr;
`endif

    // Synchroniser flops reset high; r_sync_primed stops the reset value from
    // counting as "seen high", so a line held low after reset never starts a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta     <= 1'b1;
            r_rx_sync     <= 1'b1;
            r_rx_prev     <= 1'b0;
            r_sync_primed <= 2'b00;
        end else begin
            r_rx_meta     <= uart_rx_i;
            r_rx_sync     <= r_rx_meta;
            r_rx_prev     <= r_rx_sync & r_sync_primed[1];
            r_sync_primed <= {r_sync_primed[0], 1'b1};
        end
    end

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_bit_tick = (r_bit_cnt == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_push       = 1'b0;
        w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_set   = 1'b0;
`endif
        case (r_state)
            IDLE:  if (w_fall) w_state_next = START;
            START: if (r_bit_cnt == CntHalf) w_state_next = r_rx_sync ? IDLE : DATA;
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_bit_tick) begin
                    w_state_next = STOP;
                    w_perr_set   = (^r_shift) ^ r_rx_sync;
                end
            end
`endif
            STOP: begin
                if (w_bit_tick) begin
                    w_state_next = IDLE;
                    if (r_rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~r_par_err;
`else
                        w_push = 1'b1;
`endif
                    end else begin
                        w_ferr_set = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == IDLE || w_state_next != r_state || w_bit_tick) r_bit_cnt <= '0;
            else                                                          r_bit_cnt <= r_bit_cnt + CntOne;
            if (r_state != DATA) r_bit_idx <= '0;
            else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift_en) r_shift <= {r_rx_sync, r_shift[7:1]};
        end
    end

    rx_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (r_shift),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_req_off  = {device_addr_i[3:2], 2'b00};
    assign w_rd       = device_req_i & ~device_we_i;
    assign w_wr       = device_req_i & device_we_i;
    assign w_pop      = w_rd & (w_req_off == ADDR_RX_DATA) & ~w_fifo_empty;
    assign w_ovr_set  = w_push & w_fifo_full & ~w_pop;
    assign w_ovr_clr  = w_wr & (w_req_off == ADDR_STATUS) & device_wdata_i[STATUS_OVR];
    assign w_ferr_clr = w_wr & (w_req_off == ADDR_STATUS) & device_wdata_i[STATUS_FERR];
`ifdef UART_RX_PARITY_EN
    assign w_perr_clr = w_wr & (w_req_off == ADDR_STATUS) & device_wdata_i[STATUS_PERR];
`endif

    // Sticky flags: a set in the same cycle as a software clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ie   <= 1'b0;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_par_err <= 1'b0;
`endif
        end else begin
            if (w_wr && w_req_off == ADDR_CTRL) r_ie <= device_wdata_i[0];
            r_ovr  <= w_ovr_set  | (r_ovr  & ~w_ovr_clr);
            r_ferr <= w_ferr_set | (r_ferr & ~w_ferr_clr);
`ifdef UART_RX_PARITY_EN
            r_perr    <= w_perr_set | (r_perr & ~w_perr_clr);
            r_par_err <= (r_state == IDLE) ? 1'b0 : (r_par_err | w_perr_set);
`endif
        end
    end

    always_comb begin
        w_status                              = '0;
        w_status[STATUS_NONEMPTY]             = ~w_fifo_empty;
        w_status[STATUS_FULL]                 = w_fifo_full;
        w_status[STATUS_OVR]                  = r_ovr;
        w_status[STATUS_FERR]                 = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_status[STATUS_PERR]                 = r_perr;
`endif
        w_status[STATUS_COUNT_LSB +: 8]       = 8'(w_fifo_count);
    end

    always_comb begin
        w_rdata_next = '0;
        if (w_rd) begin
            case (w_req_off)
                ADDR_RX_DATA: if (!w_fifo_empty) w_rdata_next = {24'b0, w_fifo_rdata};
                ADDR_STATUS:  w_rdata_next = w_status;
                ADDR_CTRL:    w_rdata_next = {31'b0, r_ie};
                default:      w_rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= device_req_i;
            r_rdata  <= w_rdata_next;
        end
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign rx_irq_o        = r_ie & ~w_fifo_empty;
    assign w_unused_bus    = ^{device_addr_i, device_be_i, device_wdata_i};

endmodule
